// File: rtl/ds1302_pkg.sv
// ============================================================================
// Module   : ds1302_pkg
// Brief    : Shared state encoding and timing constants for the DS1302 engine
// Revision : 1.0
// ============================================================================
`default_nettype none

package ds1302_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_CMD     = 3'd2,
    ST_WDATA   = 3'd3,
    ST_RDATA   = 3'd4,
    ST_HOLD    = 3'd5,
    ST_RECOVER = 3'd6
  } state_t;

  localparam int SETUP_TICKS   = 2;
  localparam int HOLD_TICKS    = 1;
  localparam int RECOVER_TICKS = 2;
  localparam int CMD_BITS      = 8;
  localparam int DATA_BITS     = 8;

  // Longest state is 16 ticks, so 5 bits cover every per-state tick index.
  localparam int TICK_IDX_W    = 5;

endpackage

`default_nettype wire

// File: rtl/ds1302_tick_gen.sv
// ============================================================================
// Module   : ds1302_tick_gen
// Brief    : SCLK half-period timer with per-state tick index and last-tick flag
// Revision : 1.0
// ============================================================================
`default_nettype none

module ds1302_tick_gen
  import ds1302_pkg::*;
#(
  parameter int CLK_DIV = 50
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  restart,
  input  logic [TICK_IDX_W-1:0] n_ticks,
  output logic                  tick,
  output logic                  tick_last,
  output logic [TICK_IDX_W-1:0] tick_idx
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0]         r_cnt;
  logic [TICK_IDX_W-1:0] r_idx;

  // tick marks the final sys_clk cycle of each half-period
  assign tick      = (r_cnt == CW'(CLK_DIV - 1));
  assign tick_last = tick && (r_idx == n_ticks - 1'b1);
  assign tick_idx  = r_idx;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (restart) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (tick) begin
      r_cnt <= '0;
      r_idx <= r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ds1302_driver.sv
// ============================================================================
// Module   : ds1302_driver
// Brief    : DS1302 3-wire bit engine: edge-triggered single-register access
// Revision : 1.0
// ============================================================================
`default_nettype none

module ds1302_driver
  import ds1302_pkg::*;
#(
  parameter int CLK_DIV = 50
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       first_wr,
  input  logic       first_rd,
  input  logic [7:0] control_data,
  input  logic [7:0] reg_data,
  input  logic [7:0] rd_control_data,
  output logic       wr_done,
  output logic       rd_done,
  output logic [7:0] reg_data_out,
  output logic       ds_ce,
  output logic       ds_sclk,
  output logic       ds_io_out,
  output logic       ds_io_oe,
  input  logic       ds_io_in
);

  state_t                r_state, w_state_nxt;
  logic                  r_wr_q, r_rd_q, r_pend_wr, r_pend_rd, r_op_rd;
  logic [1:0]            r_io_sync;
  logic [15:0]           r_wr_buf, r_sr;
  logic [7:0]            r_rd_buf, r_rd_sr;
  logic                  w_tick, w_tick_last, w_restart;
  logic [TICK_IDX_W-1:0] w_tick_idx, w_n_ticks;

  logic w_wr_edge, w_rd_edge, w_want_wr, w_want_rd, w_start_wr, w_start_rd;

  assign w_wr_edge  = first_wr & ~r_wr_q;
  assign w_rd_edge  = first_rd & ~r_rd_q;
  assign w_want_wr  = r_pend_wr | w_wr_edge;
  assign w_want_rd  = r_pend_rd | w_rd_edge;
  assign w_start_wr = (r_state == ST_IDLE) && w_want_wr;
  assign w_start_rd = (r_state == ST_IDLE) && !w_want_wr && w_want_rd;
  // Holding the timer in restart while idle aligns the first tick to CE rise
  assign w_restart  = (w_state_nxt != r_state) || (r_state == ST_IDLE);

  ds1302_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .restart   (w_restart),
    .n_ticks   (w_n_ticks),
    .tick      (w_tick),
    .tick_last (w_tick_last),
    .tick_idx  (w_tick_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_n_ticks   = TICK_IDX_W'(1);
    ds_ce       = 1'b0;
    ds_sclk     = 1'b0;
    ds_io_out   = 1'b0;
    ds_io_oe    = 1'b0;
    wr_done     = 1'b0;
    rd_done     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_want_wr || w_want_rd) w_state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        w_n_ticks = TICK_IDX_W'(SETUP_TICKS);
        ds_ce     = 1'b1;
        ds_io_oe  = 1'b1;
        ds_io_out = r_sr[0];
        if (w_tick_last) w_state_nxt = ST_CMD;
      end
      ST_CMD: begin
        w_n_ticks = TICK_IDX_W'(2 * CMD_BITS);
        ds_ce     = 1'b1;
        ds_io_oe  = 1'b1;
        ds_sclk   = w_tick_idx[0];
        ds_io_out = r_sr[0];
        if (w_tick_last) w_state_nxt = r_op_rd ? ST_RDATA : ST_WDATA;
      end
      ST_WDATA: begin
        w_n_ticks = TICK_IDX_W'(2 * DATA_BITS);
        ds_ce     = 1'b1;
        ds_io_oe  = 1'b1;
        ds_sclk   = w_tick_idx[0];
        ds_io_out = r_sr[0];
        if (w_tick_last) w_state_nxt = ST_HOLD;
      end
      ST_RDATA: begin
        w_n_ticks = TICK_IDX_W'(2 * DATA_BITS - 1);
        ds_ce     = 1'b1;
        ds_sclk   = w_tick_idx[0];
        if (w_tick_last) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        w_n_ticks = TICK_IDX_W'(HOLD_TICKS);
        ds_ce     = 1'b1;
        if (w_tick_last) w_state_nxt = ST_RECOVER;
      end
      ST_RECOVER: begin
        w_n_ticks = TICK_IDX_W'(RECOVER_TICKS);
        if (w_tick_last) begin
          w_state_nxt = ST_IDLE;
          wr_done     = !r_op_rd;
          rd_done     = r_op_rd;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state      <= ST_IDLE;
      r_wr_q       <= 1'b0;
      r_rd_q       <= 1'b0;
      r_pend_wr    <= 1'b0;
      r_pend_rd    <= 1'b0;
      r_op_rd      <= 1'b0;
      r_io_sync    <= 2'b00;
      r_wr_buf     <= '0;
      r_rd_buf     <= '0;
      r_sr         <= '0;
      r_rd_sr      <= '0;
      reg_data_out <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_q    <= first_wr;
      r_rd_q    <= first_rd;
      r_io_sync <= {r_io_sync[0], ds_io_in};
      r_pend_wr <= w_want_wr & ~w_start_wr;
      r_pend_rd <= w_want_rd & ~w_start_rd;
      if (w_wr_edge) r_wr_buf <= {reg_data, control_data};
      if (w_rd_edge) r_rd_buf <= rd_control_data;

      // Command and write data travel as one 16-bit word, LSB first
      if (w_start_wr) begin
        r_sr    <= w_wr_edge ? {reg_data, control_data} : r_wr_buf;
        r_op_rd <= 1'b0;
      end else if (w_start_rd) begin
        r_sr    <= {8'h00, (w_rd_edge ? rd_control_data : r_rd_buf)};
        r_op_rd <= 1'b1;
      end else if (w_tick && w_tick_idx[0] &&
                   (r_state == ST_CMD || r_state == ST_WDATA)) begin
        r_sr <= {1'b0, r_sr[15:1]};
      end

      if (w_tick && !w_tick_idx[0] && r_state == ST_RDATA) begin
        r_rd_sr <= {r_io_sync[1], r_rd_sr[7:1]};
        if (w_tick_last) reg_data_out <= {r_io_sync[1], r_rd_sr[7:1]};
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ds1302_driver.sv
// ============================================================================
// Module   : tb_ds1302_driver
// Brief    : Directed bench for ds1302_driver with a small DS1302 pin model
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ds1302_driver;

  localparam int CLK_DIV = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b0;
  logic       first_wr = 1'b0, first_rd = 1'b0;
  logic [7:0] control_data = 8'h00, reg_data = 8'h00, rd_control_data = 8'h00;
  logic       wr_done, rd_done, ds_ce, ds_sclk, ds_io_out, ds_io_oe, ds_io_in;
  logic [7:0] reg_data_out;

  ds1302_driver #(.CLK_DIV(CLK_DIV)) dut (
    .sys_clk         (sys_clk),
    .sys_rst         (sys_rst),
    .first_wr        (first_wr),
    .first_rd        (first_rd),
    .control_data    (control_data),
    .reg_data        (reg_data),
    .rd_control_data (rd_control_data),
    .wr_done         (wr_done),
    .rd_done         (rd_done),
    .reg_data_out    (reg_data_out),
    .ds_ce           (ds_ce),
    .ds_sclk         (ds_sclk),
    .ds_io_out       (ds_io_out),
    .ds_io_oe        (ds_io_oe),
    .ds_io_in        (ds_io_in)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pin-level observer and DS1302 read-data model
  int         cyc = 0;
  int         ce_rises = 0, nrise = 0, ridx = 0, contention = 0;
  int         wr_cnt = 0, rd_cnt = 0, last_wr_cyc = 0, last_rd_cyc = 0;
  logic       sclk_q = 1'b0, ce_q = 1'b0;
  logic       model_drv = 1'b0, model_bit = 1'b0;
  logic [15:0] cap = '0;
  logic [7:0] model_cmd = '0, rd_val = '0;

  assign ds_io_in = model_drv ? model_bit : ds_io_out;

  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  initial forever begin
    @(negedge sys_clk);
    if (ds_ce && !ce_q) begin
      ce_rises++;
      nrise = 0;
      ridx  = 0;
    end
    if (!ds_ce) model_drv = 1'b0;
    if (ds_ce && ds_sclk && !sclk_q) begin
      cap = {ds_io_out, cap[15:1]};
      nrise++;
      if (nrise == 8) model_cmd = cap[15:8];
    end
    if (ds_ce && !ds_sclk && sclk_q && nrise >= 8 && model_cmd[0] && ridx < 8) begin
      model_drv = 1'b1;
      model_bit = rd_val[ridx];
      ridx++;
    end
    if (model_drv && ds_io_oe) contention++;
    if (wr_done) begin wr_cnt++; last_wr_cyc = cyc; end
    if (rd_done) begin rd_cnt++; last_rd_cyc = cyc; end
    sclk_q = ds_sclk;
    ce_q   = ds_ce;
  end

  task automatic wait_pulse(input bit rd, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clk);
      if (rd ? rd_done : wr_done) begin
        at = cyc;
        break;
      end
    end
  endtask

  logic [7:0] s_cmd [8] = '{8'h8E, 8'h8C, 8'h88, 8'h86, 8'h84, 8'h82, 8'h82, 8'h8E};
  logic [7:0] s_dat [8] = '{8'h00, 8'h23, 8'h12, 8'h31, 8'h25, 8'h03, 8'h04, 8'h80};

  initial begin
    int t0, at, hi, w0, r0, c0;

    repeat (3) @(negedge sys_clk);
    check_val("reset_outputs",
              {ds_ce, ds_sclk, ds_io_out, ds_io_oe, wr_done, rd_done, reg_data_out}, 0);
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);

    // Write 8E/01
    control_data = 8'h8E; reg_data = 8'h01; first_wr = 1'b1; t0 = cyc;
    check_val("wr_ce_cycle0", ds_ce, 0);
    @(negedge sys_clk);
    check_val("wr_ce_cycle1", ds_ce, 1);
    wait_pulse(0, 400, at);
    check_val("wr_latency", at - t0, 37 * CLK_DIV);
    check_val("wr_io_bits", cap, 16'h018E);
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge sys_clk);
      if (ds_ce || wr_done) hi++;
    end
    check_val("wr_ce_low_stale_level", hi, 0);
    check_val("wr_done_count", wr_cnt, 1);
    first_wr = 1'b0;
    repeat (3) @(negedge sys_clk);

    // Read 8D, model returns 23
    rd_val = 8'h23; rd_control_data = 8'h8D; first_rd = 1'b1; t0 = cyc;
    wait_pulse(1, 400, at);
    check_val("rd_latency", at - t0, 36 * CLK_DIV);
    check_val("rd_data", reg_data_out, 8'h23);
    check_val("rd_cmd_seen", model_cmd, 8'h8D);
    check_val("rd_contention", contention, 0);
    repeat (5) @(negedge sys_clk);
    first_rd = 1'b0;
    repeat (5) @(negedge sys_clk);
    check_val("rd_data_hold", reg_data_out, 8'h23);

    // Simultaneous write and read edges
    w0 = wr_cnt; r0 = rd_cnt; c0 = ce_rises;
    rd_val = 8'hA5; control_data = 8'h80; reg_data = 8'h55; rd_control_data = 8'h81;
    first_wr = 1'b1; first_rd = 1'b1;
    wait_pulse(1, 800, at);
    check_val("sim_wr_count", wr_cnt - w0, 1);
    check_val("sim_rd_count", rd_cnt - r0, 1);
    check_val("sim_wr_before_rd", (last_wr_cyc < last_rd_cyc), 1);
    check_val("sim_ce_windows", ce_rises - c0, 2);
    check_val("sim_rd_data", reg_data_out, 8'hA5);
    check_val("sim_contention", contention, 0);
    @(negedge sys_clk);
    first_wr = 1'b0; first_rd = 1'b0;
    repeat (3) @(negedge sys_clk);

    // Reset at tick 10 of a read
    rd_val = 8'h3C; rd_control_data = 8'h8F; first_rd = 1'b1;
    repeat (10 * CLK_DIV) @(negedge sys_clk);
    sys_rst = 1'b0;
    #1;
    check_val("midrst_outputs",
              {ds_ce, ds_sclk, ds_io_out, ds_io_oe, wr_done, rd_done, reg_data_out}, 0);
    first_rd = 1'b0;
    r0 = rd_cnt;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (200) @(negedge sys_clk);
    check_val("midrst_no_rd_done", rd_cnt - r0, 0);
    control_data = 8'h8C; reg_data = 8'h23; first_wr = 1'b1; t0 = cyc;
    wait_pulse(0, 400, at);
    check_val("post_rst_wr_latency", at - t0, 37 * CLK_DIV);
    check_val("post_rst_wr_bits", cap, 16'h238C);
    @(negedge sys_clk);
    first_wr = 1'b0;
    repeat (3) @(negedge sys_clk);

    // Sequencer stream of 8 writes
    w0 = wr_cnt; c0 = ce_rises;
    for (int k = 0; k < 8; k++) begin
      @(negedge sys_clk);
      control_data = s_cmd[k]; reg_data = s_dat[k]; first_wr = 1'b1;
      wait_pulse(0, 400, at);
      check_val($sformatf("stream_bits_%0d", k), cap, {s_dat[k], s_cmd[k]});
      @(negedge sys_clk);
      first_wr = 1'b0;
    end
    repeat (200) @(negedge sys_clk);
    check_val("stream_wr_done_count", wr_cnt - w0, 8);
    check_val("stream_ce_windows", ce_rises - c0, 8);
    check_val("final_contention", contention, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
